// File: rtl/wb_pixel_port.sv
// Wishbone classic slave: pixel FIFO toward the RLBP macro, result readback
// and a 16-bit status word on mprj_io[31:16].
module wb_pixel_port #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        pix_valid_o,
    output logic [7:0]  pix_data_o,
    input  logic        pix_ready_i,
    input  logic        res_valid_i,
    input  logic [7:0]  res_data_i,
    output logic [15:0] io_out_o,
    output logic [15:0] io_oeb_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_PIX    = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_IO     = 8'h10;

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          en_q, en_d;
    logic [15:0]   io_q, io_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    res_q, res_d;
    logic          rv_q, rv_d;

    logic          hit, acc, wr, rd;
    logic [7:0]    off;
    logic          empty, full, pop, push, push_ok, clr;
    logic [31:0]   status;

    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:16]};

    always_comb begin
        hit     = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
        acc     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
        wr      = acc & wbs_we_i;
        rd      = acc & ~wbs_we_i;
        off     = wbs_adr_i[7:0];
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(FIFO_DEPTH));
        pop     = en_q & ~empty & pix_ready_i;
        push    = wr & (off == OFF_PIX);
        clr     = wr & (off == OFF_CTRL) & wbs_dat_i[1];
        // A full FIFO still takes a push when the head leaves on the same edge
        push_ok = push & (~full | pop);
        status  = {24'h0, ovf_q, rv_q, 4'(cnt_q), full, empty};
    end

    always_comb begin
        ack_d = acc;
        dat_d = '0;
        en_d  = en_q;
        io_d  = io_q;
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        res_d = res_q;
        rv_d  = rv_q;

        if (rd) begin
            case (off)
                OFF_CTRL:   dat_d = {31'h0, en_q};
                OFF_STATUS: dat_d = status;
                OFF_RESULT: dat_d = {24'h0, res_q};
                OFF_IO:     dat_d = {16'h0, io_q};
                default:    dat_d = '0;
            endcase
        end

        if (wr && off == OFF_CTRL) en_d = wbs_dat_i[0];
        if (wr && off == OFF_IO)   io_d = wbs_dat_i[15:0];

        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wp_q] = wbs_dat_i[7:0];
                wp_d        = wp_q + AW'(1);
            end
            if (pop) rp_d = rp_q + AW'(1);
            if (push_ok && !pop) cnt_d = cnt_q + CW'(1);
            if (pop && !push_ok) cnt_d = cnt_q - CW'(1);
            if (push && !push_ok) ovf_d = 1'b1;
        end

        if (rd && off == OFF_RESULT) rv_d = 1'b0;
        if (res_valid_i) begin
            res_d = res_data_i;
            rv_d  = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            en_q  <= 1'b0;
            io_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            res_q <= '0;
            rv_q  <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            en_q  <= en_d;
            io_q  <= io_d;
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            rv_q  <= rv_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign pix_valid_o = en_q & ~empty;
    assign pix_data_o  = mem_q[rp_q];
    assign io_out_o    = io_q;
    assign io_oeb_o    = '0;

endmodule

// File: tb/tb_wb_pixel_port.sv
// Bench for wb_pixel_port: register vectors, FIFO/result/reset sequences
// and a randomized run against a queue-based reference model.
module tb_wb_pixel_port;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        pvalid;
    logic [7:0]  pdata;
    logic        pready;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [15:0] io_out, io_oeb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_pixel_port #(.BASE_ADR(BASE), .FIFO_DEPTH(8)) dut (
        .wb_clk_i   (clk),
        .wb_rstn_i  (rstn),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .pix_valid_o(pvalid),
        .pix_data_o (pdata),
        .pix_ready_i(pready),
        .res_valid_i(rvalid),
        .res_data_i (rdata),
        .io_out_o   (io_out),
        .io_oeb_o   (io_oeb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
        adr = '0; dat_i = '0; pready = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wb_acc(input logic w, input logic [7:0] off,
                          input logic [31:0] wd, output logic [31:0] rd);
        int lat;
        lat = -1;
        rd = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); dat_i = wd;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_latency", 32'(lat), 32'd0);
        @(posedge clk); #1;
        check("ack_drop", {31'h0, ack}, 32'h0);
        check("dat_idle", dat_o, 32'h0);
    endtask

    task automatic wb_wr(input logic [7:0] off, input logic [31:0] wd);
        logic [31:0] d;
        wb_acc(1'b1, off, wd, d);
    endtask

    task automatic wb_rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_acc(1'b0, off, 32'h0, d);
        check(name, d, exp);
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [15:0] exp_io;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic run_random(input int n);
        logic [7:0]  m_q[$];
        bit          m_en, m_ovf, m_rv, m_ack;
        logic [7:0]  m_res;
        logic [15:0] m_io;
        bit          hit, a, pop, push, clr;
        logic [7:0]  off;
        logic [31:0] wd, exp_rd;
        int          sz;
        m_en = 0; m_ovf = 0; m_rv = 0; m_ack = 0; m_res = '0; m_io = '0;
        for (int c = 0; c < n; c++) begin
            off   = 8'($urandom_range(0, 5) * 4);
            hit   = ($urandom_range(0, 7) != 0);
            stb   = ($urandom_range(0, 2) == 0);
            cyc   = stb;
            we    = $urandom_range(0, 1);
            wd    = $urandom;
            if (off == 8'h00) begin
                wd[1] = ($urandom_range(0, 7) == 0);
                wd[0] = ($urandom_range(0, 5) != 0);
            end
            adr    = (hit ? BASE : 32'h4000_0000) | 32'(off);
            dat_i  = wd;
            pready = $urandom_range(0, 1);
            rvalid = ($urandom_range(0, 9) == 0);
            rdata  = 8'($urandom);

            sz   = m_q.size();
            a    = stb && hit && !m_ack;
            pop  = m_en && sz > 0 && pready;
            exp_rd = '0;
            if (a && !we) begin
                case (off)
                    8'h00: exp_rd = {31'h0, m_en};
                    8'h04: exp_rd = {24'h0, m_ovf, m_rv, 4'(sz), sz == 8, sz == 0};
                    8'h0C: exp_rd = {24'h0, m_res};
                    8'h10: exp_rd = {16'h0, m_io};
                    default: exp_rd = '0;
                endcase
            end
            push = a && we && off == 8'h08;
            clr  = a && we && off == 8'h00 && wd[1];
            if (a && we && off == 8'h00) m_en = wd[0];
            if (a && we && off == 8'h10) m_io = wd[15:0];
            if (clr) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < 8) m_q.push_back(wd[7:0]);
                    else m_ovf = 1;
                end
            end
            if (a && !we && off == 8'h0C) m_rv = 0;
            if (rvalid) begin
                m_res = rdata;
                m_rv  = 1;
            end
            m_ack = a;

            @(posedge clk); #1;
            check("rnd_ack", {31'h0, ack}, {31'h0, m_ack});
            check("rnd_dat", dat_o, exp_rd);
            check("rnd_valid", {31'h0, pvalid}, {31'h0, m_en && m_q.size() > 0});
            if (m_en && m_q.size() > 0) check("rnd_pix", {24'h0, pdata}, {24'h0, m_q[0]});
            check("rnd_io", {16'h0, io_out}, {16'h0, m_io});
            check("rnd_oeb", {16'h0, io_oeb}, 32'h0);
        end
        cyc = 0; stb = 0; we = 0; pready = 0; rvalid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [8];
        logic [31:0] d;
        int seen;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0001, 16'h0000, "status_rst"};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0000, 16'h0000, "ctrl_rst"};
        vecs[2]  = '{1'b1, 8'h10, 32'h0000_AB60, 32'h0,         16'hAB60, "io_ab60"};
        vecs[3]  = '{1'b1, 8'h10, 32'hFFFF_AB61, 32'h0,         16'hAB61, "io_ab61"};
        vecs[4]  = '{1'b0, 8'h10, 32'h0,         32'h0000_AB61, 16'hAB61, "io_rd"};
        vecs[5]  = '{1'b1, 8'h00, 32'h0000_0001, 32'h0,         16'hAB61, "ctrl_wr"};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0001, 16'hAB61, "ctrl_rd"};
        vecs[7]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0,         16'hAB61, "unmapped_wr"};
        vecs[8]  = '{1'b0, 8'h14, 32'h0,         32'h0000_0000, 16'hAB61, "unmapped_rd"};
        vecs[9]  = '{1'b0, 8'h10, 32'h0,         32'h0000_AB61, 16'hAB61, "io_keep"};
        vecs[10] = '{1'b0, 8'h08, 32'h0,         32'h0000_0000, 16'hAB61, "pix_rd"};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,         32'h0000_0000, 16'hAB61, "result_rst"};
        vecs[12] = '{1'b0, 8'h04, 32'h0,         32'h0000_0001, 16'hAB61, "status_en"};

        do_reset();
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_pvalid", {31'h0, pvalid}, 32'h0);
        check("rst_pdata", {24'h0, pdata}, 32'h0);
        check("rst_io", {16'h0, io_out}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            wb_acc(vecs[i].w, vecs[i].off, vecs[i].wd, d);
            if (!vecs[i].w) check(vecs[i].name, d, vecs[i].exp_rd);
            check({vecs[i].name, "_io"}, {16'h0, io_out}, {16'h0, vecs[i].exp_io});
        end

        cyc = 1; stb = 1; we = 0; adr = 32'h4000_0004;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) seen++;
        end
        cyc = 0; stb = 0;
        check("unaddressed_noack", 32'(seen), 32'd0);

        // fill, overflow, drain in order
        for (int i = 0; i < 8; i++) wb_wr(8'h08, 32'h11 + 32'(i));
        wb_rd_chk("full_status", 8'h04, 32'h0000_0022);
        check("full_head", {23'h0, pvalid, pdata}, 32'h111);
        wb_wr(8'h08, 32'h19);
        wb_rd_chk("ovf_status", 8'h04, 32'h0000_00A2);
        check("ovf_head", {24'h0, pdata}, 32'h11);
        pready = 1;
        for (int i = 0; i < 8; i++) begin
            check("drain", {23'h0, pvalid, pdata}, {23'h0, 1'b1, 8'(8'h11 + i)});
            @(posedge clk); #1;
        end
        pready = 0;
        check("drain_empty", {31'h0, pvalid}, 32'h0);
        wb_rd_chk("drain_status", 8'h04, 32'h0000_0081);
        wb_wr(8'h00, 32'h3);
        wb_rd_chk("clr_status", 8'h04, 32'h0000_0001);
        wb_rd_chk("clr_ctrl", 8'h00, 32'h0000_0001);

        // push+pop on a full FIFO with wrapped pointers
        wb_wr(8'h08, 32'hA0);
        check("a0_head", {23'h0, pvalid, pdata}, 32'h1A0);
        pready = 1;
        @(posedge clk); #1;
        pready = 0;
        check("a0_gone", {31'h0, pvalid}, 32'h0);
        for (int i = 0; i < 8; i++) wb_wr(8'h08, 32'h21 + 32'(i));
        wb_rd_chk("wrap_full", 8'h04, 32'h0000_0022);
        cyc = 1; stb = 1; we = 1; adr = BASE | 32'h08; dat_i = 32'h55; pready = 1;
        @(posedge clk); #1;
        pready = 0;
        check("pushpop_ack", {31'h0, ack}, 32'h1);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        wb_rd_chk("pushpop_status", 8'h04, 32'h0000_0022);
        exp_b = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h55};
        pready = 1;
        for (int i = 0; i < 8; i++) begin
            check("wrap_drain", {23'h0, pvalid, pdata}, {23'h0, 1'b1, exp_b[i]});
            @(posedge clk); #1;
        end
        pready = 0;
        wb_rd_chk("wrap_empty", 8'h04, 32'h0000_0001);

        // result capture
        rvalid = 1; rdata = 8'h5A;
        @(posedge clk); #1;
        rvalid = 0;
        wb_rd_chk("res_status", 8'h04, 32'h0000_0041);
        wb_rd_chk("res_read", 8'h0C, 32'h0000_005A);
        wb_rd_chk("res_cleared", 8'h04, 32'h0000_0001);
        rvalid = 1; rdata = 8'h33;
        @(posedge clk); #1;
        rvalid = 0;
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h0C; rvalid = 1; rdata = 8'h77;
        @(posedge clk); #1;
        rvalid = 0;
        check("res_race_ack", {31'h0, ack}, 32'h1);
        check("res_race_old", dat_o, 32'h0000_0033);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        wb_rd_chk("res_race_status", 8'h04, 32'h0000_0041);
        wb_rd_chk("res_race_new", 8'h0C, 32'h0000_0077);

        // reset during a pending strobe with pixels queued
        for (int i = 0; i < 3; i++) wb_wr(8'h08, 32'h61 + 32'(i));
        check("pre_rst_valid", {31'h0, pvalid}, 32'h1);
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h04; rstn = 0;
        @(posedge clk); #1;
        check("midrst_ack", {31'h0, ack}, 32'h0);
        check("midrst_pvalid", {31'h0, pvalid}, 32'h0);
        check("midrst_io", {16'h0, io_out}, 32'h0);
        check("midrst_dat", dat_o, 32'h0);
        cyc = 0; stb = 0; rstn = 1;
        @(posedge clk); #1;
        wb_rd_chk("midrst_status", 8'h04, 32'h0000_0001);
        wb_rd_chk("midrst_ctrl", 8'h00, 32'h0000_0000);

        do_reset();
        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_pixel_port.md
Name: wb_pixel_port

Overview:
- Wishbone classic slave inside the user project wrapper.
- Gives firmware a register window for three jobs:
  - pushing 8-bit pixels through an 8-deep FIFO into the RLBP macro;
  - reading back the macro's 8-bit result;
  - driving a 16-bit status word onto user I/O mprj_io[31:16].
- The firmware check protocol (0xAB60 start, 0xAB61 pass) rides on this status word.

Parameters:
- BASE_ADR, 32'h3000_0000, window base; slave selected when wbs_adr_i[31:8] == BASE_ADR[31:8].
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, at least 2.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rstn_i  in  1  synchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- pix_valid_o  out  1  FIFO head valid toward the macro.
- pix_data_o  out  8  FIFO head pixel.
- pix_ready_i  in  1  macro accepts the head.
- res_valid_i  in  1  macro result strobe, 1 cycle.
- res_data_i  in  8  macro result.
- io_out_o  out  16  status word to mprj_io[31:16].
- io_oeb_o  out  16  output-enable-bar; constant 16'h0000 (driven).

Behaviour:
- Reset (wb_rstn_i low at a clock edge): every output and every register goes to 0, except io_oeb_o, which is constant 0. This covers wbs_ack_o, wbs_dat_o, pix_valid_o, pix_data_o, io_out_o, the FIFO pointers and count, enable, result, result_valid and overflow.
- Reset mid-transaction: any pending ack is dropped and all FIFO contents are lost.
- Bus handshake:
  - Access condition: cyc & stb & addressed & !ack.
  - wbs_ack_o goes high for exactly 1 cycle on the next edge, so latency is 1 cycle.
  - ack is forced low for at least 1 cycle between accesses.
  - A write takes effect on the same edge that raises ack.
  - wbs_dat_o is valid while ack is high and returns to 0 otherwise.
  - Unaddressed strobes: no ack.
  - Unmapped offsets inside the window: ack; reads return 0; writes have no effect.
- Register map (offset = wbs_adr_i[7:0]):
  - 0x00 CTRL (RW):
    - [0] enable.
    - [1] fifo_clr, write-1 pulse. Empties the FIFO and clears overflow; reads as 0.
  - 0x04 STATUS (RO):
    - [0] empty.
    - [1] full.
    - [5:2] count, 0..FIFO_DEPTH.
    - [6] result_valid.
    - [7] overflow (sticky).
  - 0x08 PIX_WR (WO): a write pushes wbs_dat_i[7:0]. Reads return 0.
  - 0x0C RESULT (RO): reads return {24'h0, result}. The acked read clears result_valid.
  - 0x10 IO_OUT (RW): [15:0] drives io_out_o, which is registered. The new value appears on the edge that raises ack.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an explicit count.
  - Push while full: data is dropped and overflow is set.
  - Push and pop in the same cycle:
    - When full, the push is accepted and count is unchanged.
    - When count > 0 and not full, count is unchanged.
  - No bypass: a pixel pushed into an empty FIFO is visible on pix_valid_o the cycle after the push.
  - fifo_clr together with a push on the same edge: the clear wins and the pixel is discarded.
- Downstream handshake:
  - pix_valid_o = enable & !empty.
  - pix_data_o = FIFO head.
  - Pop occurs when pix_valid_o & pix_ready_i.
  - pix_data_o holds steady while valid is high and ready is low.
  - When enable = 0, valid is low and contents are retained.
- Result capture:
  - res_valid_i loads result and sets result_valid; a new result overwrites an unread one.
  - res_valid_i on the same edge as the RESULT read's ack: the read returns the old value, the new value is loaded, and result_valid stays 1.

Test Plan:
- Reset, then read STATUS → 0x0000_0001 (empty).
- Write IO_OUT = 0xAB60 → io_out_o == 16'hAB60 one cycle after the write ack.
- Write IO_OUT = 0xAB61 → io_out_o == 16'hAB61.
- CTRL = 1, pix_ready_i = 0, push 0x11..0x18 → STATUS.full = 1, count = 8, pix_data_o == 0x11 held.
  - Then push 0x19 → overflow = 1 and count stays 8.
  - Then pix_ready_i = 1 → pixels 0x11..0x18 emerge in order on consecutive cycles, and STATUS ends at empty.
- FIFO full, pix_ready_i = 1, push 0x55 on the same edge as a pop → count stays 8 and 0x55 emerges last (wrap-around check).
- Drive res_valid_i with res_data_i = 0x5A → STATUS[6] = 1.
  - Read RESULT → 0x0000_005A, then STATUS[6] = 0.
  - Repeat with res_valid_i on the same edge as the read ack → read returns the old value, STATUS[6] stays 1.
- Drop wb_rstn_i during a pending strobe with 3 pixels queued → no ack, count = 0, io_out_o = 0, pix_valid_o = 0 on the next edge.
